// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and segment table for the LED scan controller
package led_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [2:0] ptr_t;

  typedef struct packed {
    logic       dp;
    logic [3:0] val;
  } digit_t;

  // Active-high g..a patterns, index 0 in the least significant slot.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/led_hex7seg.sv
// rtl/led_hex7seg.sv - combinational hex digit plus decimal point to segment pattern
module led_hex7seg
  import led_pkg::*;
(
  input  logic [3:0] val_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  assign seg_o = {dp_i, SEG_LUT[val_i]};

endmodule

// File: rtl/led_scan_ctrl.sv
// rtl/led_scan_ctrl.sv - 8-digit seven-segment scan controller
// Optional duty-cycle dimming with the bright port is built when LED_SCAN_DIM_EN is defined.
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int PHASE_DIV = 6250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic [7:0] digit_mask,
`ifdef LED_SCAN_DIM_EN
  input  logic [2:0] bright,
`endif
  output ptr_t       cs_pointer,
  output logic [7:0] seg,
  output logic       blank,
  output logic       frame_tick
);

  localparam int PW = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    phase_q, phase_d;
  ptr_t          ptr_q, ptr_d;
  digit_t        digit_q [NUM_DIGITS];
  digit_t        cur_digit;
  logic [7:0]    seg_q, seg_d;
  logic          blank_q, blank_d;
  logic          frame_q, frame_d;
  logic          presc_tc, slot_end, dim;

  // Outputs are computed from next-state pointer/phase so everything moves on one edge.
  always_comb begin
    presc_tc  = (presc_q == PW'(PHASE_DIV - 1));
    presc_d   = presc_tc ? '0 : presc_q + 1'b1;
    phase_d   = presc_tc ? phase_q + 3'd1 : phase_q;
    slot_end  = presc_tc && (phase_q == 3'd7);
    ptr_d     = slot_end ? ptr_q + 3'd1 : ptr_q;
    frame_d   = slot_end && (ptr_q == 3'd7);
    cur_digit = digit_q[ptr_d];
`ifdef LED_SCAN_DIM_EN
    dim       = (phase_d > bright);
`else
    dim       = 1'b0;
`endif
    blank_d   = ~digit_mask[ptr_d] | dim;
  end

  led_hex7seg u_hex7seg (
    .val_i (cur_digit.val),
    .dp_i  (cur_digit.dp),
    .seg_o (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      phase_q <= '0;
      ptr_q   <= '0;
      seg_q   <= 8'h00;
      blank_q <= 1'b1;
      frame_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_q[i] <= '0;
      end
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
      ptr_q   <= ptr_d;
      seg_q   <= seg_d;
      blank_q <= blank_d;
      frame_q <= frame_d;
      if (wr_en) begin
        digit_q[wr_addr] <= digit_t'(wr_data);
      end
    end
  end

  assign cs_pointer = ptr_q;
  assign seg        = seg_q;
  assign blank      = blank_q;
  assign frame_tick = frame_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb/tb_led_scan_ctrl.sv - scoreboard bench for led_scan_ctrl with PHASE_DIV=4
module tb_led_scan_ctrl;

  localparam int PD   = 4;
  localparam int SLOT = 8 * PD;

  typedef struct packed {
    logic [2:0] ptr;
    logic [7:0] seg;
    logic       blank;
    logic       tick;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic [7:0] digit_mask;
`ifdef LED_SCAN_DIM_EN
  logic [2:0] bright;
`endif
  logic [2:0] cs_pointer;
  logic [7:0] seg;
  logic       blank;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;

  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [4:0] mdig [8];
  exp_t       expq [$];
  int         n = 0;
  int         first_tick = -1;
  int         cnt_blank = 0;
  logic       cnt_en = 1'b0;

  led_scan_ctrl #(.PHASE_DIV(PD)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .digit_mask (digit_mask),
`ifdef LED_SCAN_DIM_EN
    .bright     (bright),
`endif
    .cs_pointer (cs_pointer),
    .seg        (seg),
    .blank      (blank),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: position in the scan is derived from cycles since reset.
  always @(posedge clk) begin
    exp_t e;
    int   p;
    int   ph;
    if (rst) begin
      n = 0;
      for (int i = 0; i < 8; i++) mdig[i] = 5'h00;
      e = '{ptr: 3'd0, seg: 8'h00, blank: 1'b1, tick: 1'b0};
    end else begin
      n++;
      p  = (n / SLOT) % 8;
      ph = (n / PD) % 8;
      e.ptr   = 3'(p);
      e.seg   = {mdig[p][4], lut[mdig[p][3:0]]};
      e.blank = ~digit_mask[p];
`ifdef LED_SCAN_DIM_EN
      if (ph > int'(bright)) e.blank = 1'b1;
`endif
      e.tick  = (n % (8 * SLOT) == 0);
      if (wr_en) mdig[wr_addr] = wr_data;
    end
    expq.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check_eq("scan_outputs", 32'({cs_pointer, seg, blank, frame_tick}), 32'(e));
    end
    if (frame_tick && first_tick < 0) first_tick = n;
    if (cnt_en && blank) cnt_blank++;
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = 3'd0;
    wr_data    = 5'h00;
    digit_mask = 8'hFF;
`ifdef LED_SCAN_DIM_EN
    bright     = 3'd7;
`endif
    step(2);
    check_eq("reset_ptr", 32'(cs_pointer), 32'd0);
    check_eq("reset_seg", 32'(seg), 32'h00);
    check_eq("reset_blank", 32'(blank), 32'd1);
    check_eq("reset_tick", 32'(frame_tick), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_addr = 3'(i);
      wr_data = 5'(i);
      step(1);
    end
    wr_en = 1'b0;

    step(59);
    check_eq("wr_ptr", 32'(cs_pointer), 32'd2);
    wr_en   = 1'b1;
    wr_addr = 3'd2;
    wr_data = 5'h1A;
    step(1);
    wr_en = 1'b0;
    check_eq("wr_seg_t1", 32'(seg), 32'h5B);
    step(1);
    check_eq("wr_seg_t2", 32'(seg), 32'hF7);

    step(231);
    digit_mask = 8'b1111_1011;
    step(212);
    cnt_blank = 0;
    cnt_en    = 1'b1;
    step(256);
    cnt_en = 1'b0;
    check_eq("mask_blank_cycles", 32'(cnt_blank), 32'd32);
    check_eq("first_tick_cycle", 32'(first_tick), 32'd256);

    digit_mask = 8'hFF;
`ifdef LED_SCAN_DIM_EN
    bright = 3'd1;
`endif
    cnt_blank = 0;
    cnt_en    = 1'b1;
    step(256);
    cnt_en = 1'b0;
`ifdef LED_SCAN_DIM_EN
    check_eq("dim1_blank_cycles", 32'(cnt_blank), 32'd192);
    bright = 3'd7;
`else
    check_eq("full_blank_cycles", 32'(cnt_blank), 32'd0);
`endif
    cnt_blank = 0;
    cnt_en    = 1'b1;
    step(256);
    cnt_en = 1'b0;
    check_eq("bright7_blank_cycles", 32'(cnt_blank), 32'd0);

    step(172);
    check_eq("pre_rst_ptr", 32'(cs_pointer), 32'd5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_eq("midrst_ptr", 32'(cs_pointer), 32'd0);
    check_eq("midrst_seg", 32'(seg), 32'h00);
    check_eq("midrst_blank", 32'(blank), 32'd1);
    step(31);
    check_eq("restart_hold_ptr", 32'(cs_pointer), 32'd0);
    step(1);
    check_eq("restart_adv_ptr", 32'(cs_pointer), 32'd1);
    check_eq("restart_cleared_seg", 32'(seg), 32'h3F);
    step(5);
    check_eq("scoreboard_drain", 32'(expq.size()), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
# led_scan_ctrl

Time-multiplexed scan controller for the 8-digit seven-segment display. Holds a per-digit value register file written by the host logic, steps the digit pointer consumed by the chip-select decoder at a fixed scan rate, and drives the registered segment pattern for the currently selected digit. An optional brightness control gates each digit slot by duty cycle.

## Interface
- `PHASE_DIV`, default 6250: clock cycles per sub-phase; one digit slot = 8 sub-phases; legal range 2..2^20.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write strobe, one digit per cycle.
- `wr_addr`  in  3  digit index 0..7.
- `wr_data`  in  5  [3:0] hex value, [4] decimal point.
- `digit_mask`  in  8  per-digit enable; 0 blanks that digit.
- `bright`  in  3  duty level 0..7; present only with `LED_SCAN_DIM_EN`.
- `cs_pointer`  out  3  selected digit, to the chip-select decoder.
- `seg`  out  8  active-high segments, [6:0]=g..a, [7]=dp.
- `blank`  out  1  1 = display off this cycle, gates the chip-select output.
- `frame_tick`  out  1  one-cycle pulse when the pointer wraps 7→0.

## Operation
- Reset values: `cs_pointer`=0, `seg`=8'h00, `blank`=1, `frame_tick`=0, prescaler=0, sub-phase=0, all digit registers=5'h00.
- Prescaler counts 0..PHASE_DIV-1. At terminal count it returns to 0 and sub-phase (0..7) increments.
- When sub-phase wraps 7→0, `cs_pointer` increments mod 8. On the 7→0 wrap, `frame_tick`=1 for that one cycle only.
- Digit register file: `wr_en` writes `wr_data` to `digit[wr_addr]`. Last write wins; there is no read port. Writes are accepted at any time, including during a slot showing that digit.
- `seg` = hex-to-7seg(`digit[ptr][3:0]`) with bit7 = `digit[ptr][4]`. Encoding 0–F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- `blank` = ~`digit_mask[ptr]` (OR with dimming term, see Configuration).
- When `blank`=1, `seg` is still driven with the decoded value. Gating is done downstream via `blank`.

## Timing
- `cs_pointer`, `seg`, `blank` and `frame_tick` are all registered and change on the same edge. There is no cycle where the pointer and segments disagree.
- Slot length is exactly 8·PHASE_DIV cycles; frame length is 64·PHASE_DIV cycles.
- Write latency: write at edge t updates the register at t+1. If that digit is selected, `seg` reflects it at t+2.
- `digit_mask` change reaches `blank` one cycle later.
- Write coinciding with a pointer advance: the register updates normally, and `seg` shows the new pointer's stored value.
- Reset asserted mid-slot: all state returns to reset values on the next edge. The scan restarts at digit 0, sub-phase 0.
- The first `frame_tick` after reset occurs at cycle 64·PHASE_DIV.

## Configuration
- `LED_SCAN_DIM_EN` defined:
  - `bright` port exists.
  - `blank` = ~`digit_mask[ptr]` | (sub-phase > `bright`), so the digit is lit (`bright`+1)/8 of each slot.
  - `bright`=7 means full on.
  - `bright` is sampled every cycle; changes apply from the next sub-phase comparison.
- Undefined:
  - No `bright` port.
  - `blank` = ~`digit_mask[ptr]` only.
  - Sub-phase counter is still present, so slot timing is identical in both builds.

## Structure
- Package `led_pkg`:
  - `NUM_DIGITS`=8.
  - `digit_t` packed struct {dp, val[3:0]}.
  - 16-entry seven-segment encoding constant.
  - pointer type `logic [2:0]`.
- Sub-module `led_hex7seg`: combinational 4-bit value + dp → 8-bit `seg`. Instantiated once on the selected digit, with its output registered in `led_scan_ctrl`.

## Test plan
All tests use `PHASE_DIV`=4.
- Reset, release, run 300 cycles → `cs_pointer` holds 0 for 32 cycles, then 1..7. First `frame_tick` at cycle 256, width 1. `blank`=1 throughout reset.
- Write digits 0..7 = 0x0..0x7, `digit_mask`=8'hFF → `seg` sequence 3F,06,5B,4F,66,6D,7D,07 aligned with the pointer. `blank`=0.
- Write `wr_addr`=2, `wr_data`=5'h1A while pointer=2 → `seg`=8'hF7 exactly two cycles after the write.
- `digit_mask`=8'b1111_1011 → `blank`=1 only during pointer=2 slots.
- `LED_SCAN_DIM_EN`, `bright`=1 → `blank`=0 for the first 8 cycles of each 32-cycle slot, 1 for the remaining 24. With `bright`=7, `blank` stays 0.
- Assert `rst` at pointer=5, sub-phase=3 for one cycle → next cycle: pointer 0, `seg` 00, `blank` 1, registers cleared. Scan restarts with a 32-cycle slot.
